block_and_nonblocking: RTL and testbench

Single-bit (parameterisable-width) synchronous delay line that registers `in` through a chain of flip-flops and presents the oldest stage on `out`. It is the reference block for register-transfer semantics: every stage updates simultaneously on the clock edge, so data advances exactly one stage per cycle, never collapsing to a single-cycle pass-through. It sits between a free-running input source and downstream logic that needs a fixed, known latency.

---
 rtl/block_and_nonblocking_pkg.sv | 12 +
 rtl/block_and_nonblocking_dff_sr.sv | 19 +
 rtl/block_and_nonblocking.sv | 44 ++++
 tb/tb_block_and_nonblocking.sv | 128 ++++++++++++
 4 files changed

// File: rtl/block_and_nonblocking_pkg.sv
// Shared constants for the block_and_nonblocking delay line.
// Holds the legal depth range and the helper that validates it.
package block_and_nonblocking_pkg;

   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 32;

   function automatic bit depth_legal(input int depth);
      return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
   endfunction

endpackage : block_and_nonblocking_pkg

// File: rtl/block_and_nonblocking_dff_sr.sv
// WIDTH-bit D flip-flop with synchronous active-high clear.
// This is one stage of the block_and_nonblocking delay line.
module dff_sr #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: non-blocking assignment lets every chained stage sample its
   // neighbour's pre-edge value, so data moves exactly one stage per edge.
   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule : dff_sr

// File: rtl/block_and_nonblocking.sv
// Fixed-latency delay line: DEPTH chained dff_sr stages, out is the oldest stage.
// There is no enable and no bypass, so the line shifts on every rising clk.
module block_and_nonblocking #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   import block_and_nonblocking_pkg::*;

   localparam bit DEPTH_LEGAL = depth_legal(DEPTH);

   logic [WIDTH-1:0] stage [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         dff_sr #(.WIDTH(WIDTH)) u_dff (
            .clk   (clk),
            .reset (reset),
            .d     (in),
            .q     (stage[0])
         );
      end else begin : g_link
         dff_sr #(.WIDTH(WIDTH)) u_dff (
            .clk   (clk),
            .reset (reset),
            .d     (stage[k-1]),
            .q     (stage[k])
         );
      end
   end

   // Output comes straight from the last flop; no combinational path from in.
   assign out = stage[DEPTH-1];

   a_depth_legal : assert property (@(posedge clk) DEPTH_LEGAL)
      else $error("block_and_nonblocking: DEPTH %0d outside %0d..%0d",
                  DEPTH, DEPTH_MIN, DEPTH_MAX);

endmodule : block_and_nonblocking

// File: tb/tb_block_and_nonblocking.sv
// Scoreboard bench for block_and_nonblocking at DEPTH=2/WIDTH=1,
// DEPTH=1/WIDTH=8 and DEPTH=5/WIDTH=8, driven in lockstep.
module tb_block_and_nonblocking;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in2 = 1'b0;
   logic [7:0] in8 = 8'h00;
   logic       out2;
   logic [7:0] out1;
   logic [7:0] out5;

   int vectors = 0;
   int miscompares = 0;

   // Reference stage contents per instance, oldest entry at index 0.
   logic [7:0] m2[$];
   logic [7:0] m1[$];
   logic [7:0] m5[$];
   // Expected outputs, pushed at drive time and popped after the edge.
   logic [7:0] exp2[$];
   logic [7:0] exp1[$];
   logic [7:0] exp5[$];

   always #5 clk = ~clk;

   block_and_nonblocking #(.WIDTH(1), .DEPTH(2)) u_d2 (
      .clk   (clk),
      .reset (reset),
      .in    (in2),
      .out   (out2)
   );

   block_and_nonblocking #(.WIDTH(8), .DEPTH(1)) u_d1 (
      .clk   (clk),
      .reset (reset),
      .in    (in8),
      .out   (out1)
   );

   block_and_nonblocking #(.WIDTH(8), .DEPTH(5)) u_d5 (
      .clk   (clk),
      .reset (reset),
      .in    (in8),
      .out   (out5)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // Drive one cycle of stimulus on the falling edge, predict, then compare
   // just after the following rising edge.
   task automatic step(input logic rst, input logic a, input logic [7:0] b, input string tag);
      @(negedge clk);
      reset = rst;
      in2   = a;
      in8   = b;
      if (rst) begin
         m2 = {};
         m1 = {};
         m5 = {};
         repeat (2) m2.push_back(8'h00);
         repeat (1) m1.push_back(8'h00);
         repeat (5) m5.push_back(8'h00);
      end else begin
         m2.push_back({7'b0, a});
         m1.push_back(b);
         m5.push_back(b);
         void'(m2.pop_front());
         void'(m1.pop_front());
         void'(m5.pop_front());
      end
      exp2.push_back(m2[0]);
      exp1.push_back(m1[0]);
      exp5.push_back(m5[0]);
      @(posedge clk);
      #1;
      check({tag, "/d2"}, {7'b0, out2}, exp2.pop_front());
      check({tag, "/d1"}, out1,         exp1.pop_front());
      check({tag, "/d5"}, out5,         exp5.pop_front());
   endtask

   initial begin
      logic [5:0] alt;
      alt = 6'b011010;

      // Reset held for two edges while in is high.
      step(1'b1, 1'b1, 8'hFF, "reset0");
      step(1'b1, 1'b1, 8'hFF, "reset1");
      repeat (3) step(1'b0, 1'b0, 8'h00, "idle");

      // Single one-cycle pulse.
      step(1'b0, 1'b1, 8'hA5, "pulse");
      repeat (6) step(1'b0, 1'b0, 8'h00, "pulse_tail");

      // Alternating stream 0,1,0,1,1,0.
      for (int i = 0; i < 6; i++)
         step(1'b0, alt[i], {7'b0, alt[i]}, $sformatf("alt%0d", i));
      repeat (6) step(1'b0, 1'b0, 8'h00, "alt_tail");

      // Fill with ones, then reset mid-stream while in stays high.
      step(1'b0, 1'b1, 8'h11, "load0");
      step(1'b0, 1'b1, 8'h22, "load1");
      step(1'b1, 1'b1, 8'h33, "midreset");
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 8'h44, $sformatf("post_reset%0d", i));

      // Wide stream 0x00..0x0F through every depth.
      step(1'b1, 1'b0, 8'h00, "sweep_reset");
      for (int i = 0; i < 16; i++)
         step(1'b0, i[0], i[7:0], $sformatf("sweep%0d", i));
      repeat (6) step(1'b0, 1'b0, 8'h00, "sweep_tail");

      // Constant input for ten cycles.
      step(1'b1, 1'b0, 8'h00, "const_reset");
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 8'h01, $sformatf("const%0d", i));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_block_and_nonblocking
